// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mips_defs
// Purpose  : Shared encodings for the instruction fetch unit
// Revision : 1.0  initial release
// ============================================================================
package mips_defs;

    localparam logic [1:0]  NPC_SEQ  = 2'b00;
    localparam logic [1:0]  NPC_BR   = 2'b01;
    localparam logic [1:0]  NPC_J    = 2'b10;
    localparam logic [1:0]  NPC_JR   = 2'b11;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/ifu_if.sv
`default_nettype none
// ============================================================================
// Interface : ifu_if
// Purpose   : Instruction-memory read port (word address out, word back)
// Revision  : 1.0  initial release
// ============================================================================
interface ifu_if;
    logic [13:2] IMaddr;
    logic [31:0] IMout;

    modport master (output IMaddr, input  IMout);
    modport slave  (input  IMaddr, output IMout);
endinterface
`default_nettype wire

// File: rtl/ifu_npc.sv
`default_nettype none
// ============================================================================
// Module   : npc
// Purpose  : Combinational next-PC selection and jal link value
// Revision : 1.0  initial release
// ============================================================================
module npc
    import mips_defs::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] ra_val,
    output logic [31:0] npc,
    output logic [31:0] pc_plus8
);

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off;

    assign w_pc_plus4 = pc + 32'd4;
    assign pc_plus8   = pc + 32'd8;
    // Branch offset is relative to the delay-slot address (PC+4)
    assign w_br_off   = {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        npc = w_pc_plus4;
        case (npc_sel)
            NPC_SEQ: npc = w_pc_plus4;
            NPC_BR:  npc = br_taken ? (w_pc_plus4 + w_br_off) : w_pc_plus4;
            NPC_J:   npc = {pc[31:28], imm26, 2'b00};
            NPC_JR:  npc = ra_val;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ifu.sv
`default_nettype none
// ============================================================================
// Module   : ifu
// Purpose  : Instruction fetch unit: PC register, RUN/HALT FSM, fetch range check
// Revision : 1.0  initial release
// ============================================================================
module ifu
    import mips_defs::*;
#(
    parameter logic [31:0] PC_RESET = mips_defs::PC_RESET,
    parameter int          IM_WORDS = 4096
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [1:0]   npc_sel,
    input  logic         br_taken,
    input  logic [15:0]  imm16,
    input  logic [25:0]  imm26,
    input  logic [31:0]  ra_val,
    ifu_if.master        imem,
    output logic [31:0]  instr,
    output logic [31:0]  pc,
    output logic [31:0]  pc_plus8,
    output logic         exc_adel,
    output logic         halted
);

    localparam logic [31:0] C_PC_LAST = PC_RESET + 32'(4 * IM_WORDS - 4);

    state_e      r_state;
    state_e      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic        r_exc;
    logic        w_exc_next;
    logic [31:0] w_npc;
    logic [31:0] w_off;
    logic        w_bad;
    logic [17:0] w_unused;

    npc u_npc (
        .pc       (r_pc),
        .npc_sel  (npc_sel),
        .br_taken (br_taken),
        .imm16    (imm16),
        .imm26    (imm26),
        .ra_val   (ra_val),
        .npc      (w_npc),
        .pc_plus8 (pc_plus8)
    );

    assign w_bad = (w_npc[1:0] != 2'b00) || (w_npc < PC_RESET) || (w_npc > C_PC_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_pc    <= PC_RESET;
            r_exc   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_exc   <= w_exc_next;
        end
    end

    // A bad target never reaches the PC; the fetch freezes on the last good one
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_exc_next   = r_exc;
        case (r_state)
            ST_RUN: begin
                if (en) begin
                    if (w_bad) begin
                        w_state_next = ST_HALT;
                        w_exc_next   = 1'b1;
                    end else begin
                        w_pc_next    = w_npc;
                    end
                end
            end
            ST_HALT: begin
                w_state_next = ST_HALT;
            end
            default: begin
                w_state_next = ST_HALT;
            end
        endcase
    end

    assign w_off       = r_pc - PC_RESET;
    assign imem.IMaddr = w_off[13:2];
    assign w_unused    = {w_off[31:14], w_off[1:0]} ^ 18'd0;

    assign pc       = r_pc;
    assign exc_adel = r_exc;
    assign halted   = (r_state == ST_HALT);
    assign instr    = halted ? 32'h0000_0000 : imem.IMout;

endmodule
`default_nettype wire

// File: doc/ifu.md
# ifu

Instruction fetch unit for the single-cycle MIPS datapath: the initiator side of the instruction-memory read interface. It holds the program counter and computes the next PC from the sequential, branch, jump and register-jump paths. It drives the word address into instruction memory and returns the fetched instruction together with PC-related values for the decode and writeback stages. An illegal fetch address halts fetch until reset.

## Interface
Parameters:
- `PC_RESET`, 32'h0000_3000: PC value after reset; also the base of instruction space.
- `IM_WORDS`, 4096: instruction-memory depth in words. Valid PC range is `PC_RESET` to `PC_RESET + 4*IM_WORDS - 4`.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  PC update enable; 0 means stall (PC holds).
- `npc_sel`  in  2  next-PC source: 00 = PC+4, 01 = branch, 10 = j/jal, 11 = jr.
- `br_taken`  in  1  branch condition from the comparator; used only when `npc_sel`=01.
- `imm16`  in  16  branch offset field.
- `imm26`  in  26  jump index field.
- `ra_val`  in  32  register operand for jr.
- `IMout`  in  32  instruction word returned by instruction memory.
- `IMaddr`  out  [13:2]  word address to instruction memory, equal to (PC − `PC_RESET`)[13:2].
- `instr`  out  32  current instruction; equals `IMout` in RUN and 32'h0000_0000 (nop) in HALT.
- `pc`  out  32  current PC.
- `pc_plus8`  out  32  PC+8 link value for jal.
- `exc_adel`  out  1  fetch address error flag.
- `halted`  out  1  1 while the FSM is in HALT.

## Operation
- State machine with two states, RUN and HALT.
- Next-PC candidate `npc`:
  - 00: PC+4.
  - 01: if `br_taken`, PC+4+(sext(imm16)<<2); otherwise PC+4.
  - 10: {PC[31:28], imm26, 2'b00}.
  - 11: `ra_val`.
- Arithmetic is 32-bit modulo 2^32; no overflow detection.
- `bad(x)` is true when x[1:0]≠0, or x<`PC_RESET`, or x>`PC_RESET`+4*`IM_WORDS`−4.
- RUN transitions, at a rising edge with `en`=1:
  - If `bad(npc)`: PC holds, state goes to HALT, `exc_adel` latches to 1.
  - Otherwise: PC ← `npc`.
- RUN with `en`=0: PC and state hold, and no error check is made on `npc`.
- HALT: PC, state and `exc_adel` hold regardless of `en` and `npc_sel`. The only exit is `reset`.
- `reset` is sampled at the rising edge and overrides everything, including a mid-stall or HALT state.

## Timing
- Reset values: PC=`PC_RESET`, state=RUN, `exc_adel`=0, `halted`=0, `IMaddr`=12'h000, `pc_plus8`=`PC_RESET`+8.
- `IMaddr`, `pc` and `pc_plus8` are purely combinational from the PC register. `instr` is combinational from `IMout`, which the memory drives combinationally. The fetch therefore completes in the same cycle the PC is valid (zero-cycle read).
- Next-PC has one-cycle latency: control inputs sampled at edge N define PC from edge N onward.
- `exc_adel` and `halted` rise at the same edge that would have loaded the bad PC.

## Structure
- A shared package `mips_defs` holds:
  - `NPC_SEQ`/`NPC_BR`/`NPC_J`/`NPC_JR` encodings.
  - `PC_RESET`.
  - The RUN/HALT state encoding.
- One sub-module, `npc`, is purely combinational. It takes PC, `npc_sel`, `br_taken`, `imm16`, `imm26` and `ra_val`, and produces `npc` and `pc_plus8`.
- `ifu` contains the PC register, the FSM, the `bad()` range check and the `IMaddr`/`instr` muxing.

## Test plan
- Reset then 3 cycles with `en`=1, `npc_sel`=00 → `pc` is 3000, 3004, 3008, 300C; `IMaddr` is 000, 001, 002, 003; `instr` tracks the memory contents.
- At PC=3010 with `npc_sel`=01, `imm16`=16'hFFFC:
  - `br_taken`=1 → next PC is 3004.
  - `br_taken`=0 → next PC is 3014.
- At PC=3000:
  - `npc_sel`=10, `imm26`=26'h0000C10 → next PC is 3040.
  - `npc_sel`=10 (jal) → `pc_plus8` is 3008 in the same cycle.
- Stall: `en`=0 for 2 cycles at PC=3008 → `pc` stays 3008 and `IMaddr` stays 002; with `en`=1 the PC resumes at 300C.
- Bad target:
  - `npc_sel`=11 with `ra_val`=32'h0000_3002 → PC holds, `exc_adel`=1, `halted`=1, `instr`=0, and further `npc_sel` changes have no effect.
  - `ra_val`=32'h0000_7000 gives the same result.
- Reset asserted while in HALT and while stalled → next edge gives PC=3000, `exc_adel`=0, RUN.
